fifo_4b: RTL and testbench

Four-bit-wide, parameter-depth synchronous FIFO. It is the read-side counterpart to the team's write-enabled 4-bit storage register. A producer pushes with a write enable, and a consumer drains in order through a first-word-fall-through read port with pop handshake. It is used wherever a pipeline stage must buffer narrow tags or opcodes between producer and consumer (e.g. decode-to-execute tag queue).

---
 rtl/fifo_4b_pkg.sv | 13 +
 rtl/fifo_ctrl_4b.sv | 88 ++++++++
 rtl/fifo_reg_4b.sv | 27 ++
 rtl/fifo_4b.sv | 80 ++++++++
 tb/tb_fifo_4b.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fifo_4b_pkg.sv
// rtl/fifo_4b_pkg.sv - shared constants for the 4-bit FIFO
//
// Holds the default depth and count width used by fifo_4b and fifo_ctrl_4b,
// plus the 4-bit data type of one storage entry.
package fifo_4b_pkg;

    localparam int FIFO_4B_DEPTH = 4;
    localparam int FIFO_4B_CW    = $clog2(FIFO_4B_DEPTH) + 1;
    localparam int FIFO_4B_DW    = 4;

    typedef logic [FIFO_4B_DW-1:0] fifo_4b_data_t;

endpackage

// File: rtl/fifo_ctrl_4b.sv
// rtl/fifo_ctrl_4b.sv - pointer, occupancy and error control for fifo_4b
//
// Optional feature: FIFO_4B_ERR_EN adds the sticky err output.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   write_en   - raw push request
//   read_en    - raw pop request
//   push, pop  - qualified (accepted) push / pop this cycle
//   wp, rp     - write / read pointers, wrap modulo DEPTH
//   count      - occupancy 0..DEPTH
//   out_valid  - FIFO non-empty
//   full       - count == DEPTH
//   err        - sticky overflow/underflow flag (FIFO_4B_ERR_EN only)
module fifo_ctrl_4b
    import fifo_4b_pkg::*;
#(
    parameter int DEPTH = FIFO_4B_DEPTH,
    parameter int CW    = FIFO_4B_CW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic          read_en,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] wp,
    output logic [AW-1:0] rp,
    output logic [CW-1:0] count,
    output logic          out_valid,
    output logic          full
`ifdef FIFO_4B_ERR_EN
    ,
    output logic          err
`endif
);

    always_comb begin
        full      = (count == CW'(DEPTH));
        out_valid = (count != '0);
        // A full FIFO still takes a push when the head is leaving in the same
        // cycle: the new entry lands in the slot being freed. An empty FIFO
        // never pops, even with a simultaneous push (no bypass).
        push      = write_en && (!full || read_en);
        pop       = read_en && out_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_4B_ERR_EN
    logic overflow;
    logic underflow;

    always_comb begin
        overflow  = write_en && full && !read_en;
        underflow = read_en && !out_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (overflow || underflow) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/fifo_reg_4b.sv
// rtl/fifo_reg_4b.sv - 4-bit write-enabled storage register
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears q to 4'h0
//   en   - load enable
//   d    - data in
//   q    - registered data out
module fifo_reg_4b
    import fifo_4b_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  fifo_4b_data_t d,
    output fifo_4b_data_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo_4b.sv
// rtl/fifo_4b.sv - 4-bit first-word-fall-through synchronous FIFO
//
// Optional feature: FIFO_4B_ERR_EN adds the sticky err output.
//
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   inData   - push data
//   writeEn  - push request
//   readEn   - pop request (consumer took outData this cycle)
//   outData  - head entry, valid when outValid
//   outValid - FIFO non-empty
//   full     - count == DEPTH
//   count    - occupancy 0..DEPTH
//   err      - sticky protocol-error flag (FIFO_4B_ERR_EN only)
module fifo_4b
    import fifo_4b_pkg::*;
#(
    parameter int DEPTH = FIFO_4B_DEPTH,
    parameter int CW    = FIFO_4B_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    inData,
    input  logic          writeEn,
    input  logic          readEn,
    output logic [3:0]    outData,
    output logic          outValid,
    output logic          full,
    output logic [CW-1:0] count
`ifdef FIFO_4B_ERR_EN
    ,
    output logic          err
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic          push;
    logic          pop;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    fifo_4b_data_t entry [DEPTH];

    fifo_ctrl_4b #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .AW    (AW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .write_en  (writeEn),
        .read_en   (readEn),
        .push      (push),
        .pop       (pop),
        .wp        (wp),
        .rp        (rp),
        .count     (count),
        .out_valid (outValid),
        .full      (full)
`ifdef FIFO_4B_ERR_EN
        ,
        .err       (err)
`endif
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        fifo_reg_4b u_reg (
            .clk (clk),
            .rst (rst),
            .en  (push && (wp == AW'(i))),
            .d   (inData),
            .q   (entry[i])
        );
    end

    // Fall-through head: no read latency, the entry at rp is always on outData.
    assign outData = entry[rp];

endmodule

// File: tb/tb_fifo_4b.sv
// tb/tb_fifo_4b.sv - randomized self-checking bench for fifo_4b
module tb_fifo_4b;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    inData;
    logic          writeEn;
    logic          readEn;
    logic [3:0]    outData;
    logic          outValid;
    logic          full;
    logic [CW-1:0] count;
`ifdef FIFO_4B_ERR_EN
    logic          err;
`endif

    fifo_4b #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .writeEn  (writeEn),
        .readEn   (readEn),
        .outData  (outData),
        .outValid (outValid),
        .full     (full),
        .count    (count)
`ifdef FIFO_4B_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO contents as a queue, plus the sticky error bit.
    logic [3:0] model_q [$];
    bit         model_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".valid"}, 32'(outValid), 32'(model_q.size() != 0));
        check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        if (model_q.size() != 0)
            check({tag, ".head"}, 32'(outData), 32'(model_q[0]));
`ifdef FIFO_4B_ERR_EN
        check({tag, ".err"}, 32'(err), 32'(model_err));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model by the FIFO rules,
    // then compare after the edge.
    task automatic step(input string tag, input bit r, input bit we, input bit re, input logic [3:0] d);
        bit was_full;
        bit was_empty;
        bit do_push;
        bit do_pop;
        rst     = r;
        writeEn = we;
        readEn  = re;
        inData  = d;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        do_push   = we && (!was_full || re);
        do_pop    = re && !was_empty;
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            if ((we && was_full && !re) || (re && was_empty))
                model_err = 1'b1;
            if (do_pop)
                void'(model_q.pop_front());
            if (do_push)
                model_q.push_back(d);
        end
        check_state(tag);
    endtask

    initial begin
        rst = 1'b1; writeEn = 1'b0; readEn = 1'b0; inData = 4'h0;
        model_err = 1'b0;

        // Reset with a push request held: reset wins.
        step("rst0", 1'b1, 1'b1, 1'b0, 4'hF);
        step("rst1", 1'b1, 1'b1, 1'b0, 4'hF);
        writeEn = 1'b0;
        check("rst.count", 32'(count), 32'd0);
        check("rst.valid", 32'(outValid), 32'd0);
        check("rst.full", 32'(full), 32'd0);
        check("rst.data", 32'(outData), 32'h0);
`ifdef FIFO_4B_ERR_EN
        check("rst.err", 32'(err), 32'd0);
`endif

        // Fill then drain in order.
        for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b1, 1'b0, 4'(i));
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain.head", 32'(outData), 32'(i));
            step("drain", 1'b0, 1'b0, 1'b1, 4'h0);
        end
        check("drain.valid", 32'(outValid), 32'd0);

        // Full with simultaneous push/pop, then overflow.
        for (int i = 1; i <= 4; i++) step("refill", 1'b0, 1'b1, 1'b0, 4'(i));
        step("fullpp", 1'b0, 1'b1, 1'b1, 4'hA);
        check("fullpp.count", 32'(count), 32'd4);
        check("fullpp.head", 32'(outData), 32'h2);
        step("ovf", 1'b0, 1'b1, 1'b0, 4'hB);
        check("ovf.count", 32'(count), 32'd4);
        check("ovf.head", 32'(outData), 32'h2);
`ifdef FIFO_4B_ERR_EN
        check("ovf.err", 32'(err), 32'd1);
`endif
        begin
            logic [3:0] exp_seq [4];
            exp_seq = '{4'h2, 4'h3, 4'h4, 4'hA};
            for (int i = 0; i < 4; i++) begin
                check("drain2.head", 32'(outData), 32'(exp_seq[i]));
                step("drain2", 1'b0, 1'b0, 1'b1, 4'h0);
            end
        end

        // Empty with simultaneous push/pop: push wins, no bypass.
        step("emptypp", 1'b0, 1'b1, 1'b1, 4'h7);
        check("emptypp.count", 32'(count), 32'd1);
        check("emptypp.head", 32'(outData), 32'h7);
`ifdef FIFO_4B_ERR_EN
        check("emptypp.err", 32'(err), 32'd1);
`endif
        step("empty1", 1'b0, 1'b0, 1'b1, 4'h0);

        // Wrap-around: alternate push and pop.
        for (int i = 0; i < 10; i++) begin
            step("wrap.push", 1'b0, 1'b1, 1'b0, 4'(i));
            check("wrap.head", 32'(outData), 32'(i));
            step("wrap.pop", 1'b0, 1'b0, 1'b1, 4'h0);
        end

        // Randomized traffic with occasional mid-operation reset.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        step("final_rst", 1'b1, 1'b0, 1'b0, 4'h0);
        check("final.count", 32'(count), 32'd0);
        check("final.data", 32'(outData), 32'h0);
`ifdef FIFO_4B_ERR_EN
        check("final.err", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
